// File: rtl/ldpc_bf_decoder_if.sv
// Bundle of the decoder's channel, H_ROM and control handshakes.
// master: channel/ROM/control side; slave: the decoder itself.
interface ldpc_bf_decoder_if #(
   parameter int CodeLen   = 256,
   parameter int ITER_bits = 6
);
   logic                 code_ready;
   logic [CodeLen-1:0]   code_in;
   logic                 code_ready_receive;
   logic                 decoder_read_H;
   logic                 H_read_receive;
   logic                 H_valid;
   logic [CodeLen-1:0]   dout_H;
   logic                 decode_down;
   logic                 decode_down_receive;
   logic [CodeLen-1:0]   Decoded_sequence;
   logic                 decode_success;
   logic [ITER_bits-1:0] iter_cnt;

   modport master (
      output code_ready, code_in, H_read_receive, H_valid, dout_H,
      output decode_down_receive,
      input  code_ready_receive, decoder_read_H, decode_down,
      input  Decoded_sequence, decode_success, iter_cnt
   );

   modport slave (
      input  code_ready, code_in, H_read_receive, H_valid, dout_H,
      input  decode_down_receive,
      output code_ready_receive, decoder_read_H, decode_down,
      output Decoded_sequence, decode_success, iter_cnt
   );
endinterface

// File: rtl/ldpc_bf_decoder.sv
// Hard-decision bit-flipping LDPC decoder; H streamed row by row.
// Ports: clk, rst (async active-low), bus (slave side of ldpc_bf_decoder_if).
module ldpc_bf_decoder #(
   parameter int CodeLen         = 256,
   parameter int ChkLen          = 128,
   parameter int ChkLen_bits     = 8,
   parameter int column_weight   = 3,
   parameter int CNT_bits        = 3,
   parameter int Iteration_Times = 50,
   parameter int ITER_bits       = 6
) (
   input logic clk,
   input logic rst,
   ldpc_bf_decoder_if.slave bus
);

   typedef enum logic [2:0] {IDLE, REQ, ACC, EVAL, DONE} state_t;

   localparam logic [CNT_bits-1:0]    CMAX  = '1;
   localparam logic [ChkLen_bits-1:0] LAST  = ChkLen_bits'(ChkLen - 1);
   localparam logic [ITER_bits-1:0]   ITMAX = ITER_bits'(Iteration_Times);
   // Saturation guard only matters if a column can reach the cap.
   localparam bit SAT = (column_weight >= (2 ** CNT_bits) - 1);

   state_t                  st;
   logic [CodeLen-1:0]      cw;
   logic [CNT_bits-1:0]     cnt [CodeLen];
   logic [ChkLen_bits-1:0]  row;
   logic                    syn;
   logic [ITER_bits-1:0]    it;
   logic [ITER_bits-1:0]    it_nx;
   logic                    s;
   logic [CNT_bits-1:0]     mx;
   logic [CodeLen-1:0]      fm;

   assign s     = ^(bus.dout_H & cw);
   assign it_nx = it + 1'b1;

   always_comb begin
      mx = '0;
      for (int j = 0; j < CodeLen; j++)
         if (cnt[j] > mx) mx = cnt[j];
   end

   // Bits sharing the worst unsatisfied count get flipped together.
   always_comb begin
      fm = '0;
      for (int j = 0; j < CodeLen; j++)
         fm[j] = (cnt[j] == mx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st                     <= IDLE;
         cw                     <= '0;
         row                    <= '0;
         syn                    <= 1'b0;
         it                     <= '0;
         for (int j = 0; j < CodeLen; j++) cnt[j] <= '0;
         bus.code_ready_receive <= 1'b0;
         bus.decoder_read_H     <= 1'b0;
         bus.decode_down        <= 1'b0;
         bus.Decoded_sequence   <= '0;
         bus.decode_success     <= 1'b0;
         bus.iter_cnt           <= '0;
      end else begin
         bus.code_ready_receive <= 1'b0;
         unique case (st)
            IDLE: begin
               if (bus.code_ready) begin
                  cw                     <= bus.code_in;
                  it                     <= '0;
                  bus.code_ready_receive <= 1'b1;
                  bus.decoder_read_H     <= 1'b1;
                  st                     <= REQ;
               end
            end
            REQ: begin
               if (bus.H_read_receive) begin
                  bus.decoder_read_H <= 1'b0;
                  row                <= '0;
                  syn                <= 1'b0;
                  for (int j = 0; j < CodeLen; j++) cnt[j] <= '0;
                  st                 <= ACC;
               end
            end
            ACC: begin
               if (bus.H_valid) begin
                  if (s) begin
                     syn <= 1'b1;
                     for (int j = 0; j < CodeLen; j++)
                        if (bus.dout_H[j] && (!SAT || cnt[j] != CMAX))
                           cnt[j] <= cnt[j] + 1'b1;
                  end
                  row <= row + 1'b1;
                  // Leave on the last row so EVAL follows immediately.
                  if (row == LAST) st <= EVAL;
               end
            end
            EVAL: begin
               it           <= it_nx;
               bus.iter_cnt <= it_nx;
               if (!syn) begin
                  bus.decode_success   <= 1'b1;
                  bus.Decoded_sequence <= cw;
                  bus.decode_down      <= 1'b1;
                  st                   <= DONE;
               end else if (it_nx == ITMAX) begin
                  bus.decode_success   <= 1'b0;
                  bus.Decoded_sequence <= cw;
                  bus.decode_down      <= 1'b1;
                  st                   <= DONE;
               end else begin
                  cw                 <= cw ^ fm;
                  bus.decoder_read_H <= 1'b1;
                  st                 <= REQ;
               end
            end
            DONE: begin
               if (bus.decode_down_receive) begin
                  bus.decode_down <= 1'b0;
                  st              <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// Self-checking bench for ldpc_bf_decoder with an H_ROM model
// and a bit-flipping reference model on a dual-diagonal H.
module tb_ldpc_bf_decoder;

   localparam int N  = 256;
   localparam int M  = 128;
   localparam int IT = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ldpc_bf_decoder_if #(.CodeLen(N), .ITER_bits(6)) bus ();

   ldpc_bf_decoder #(
      .CodeLen(N), .ChkLen(M), .ChkLen_bits(8), .column_weight(3),
      .CNT_bits(3), .Iteration_Times(IT), .ITER_bits(6)
   ) dut (
      .clk(clk), .rst(rst_n), .bus(bus)
   );

   logic [N-1:0] Hrows [M];

   int gap = 0, rdly = 0, nextra = 0;
   int ph = 0, dly = 0, row = 0, ex = 0, tog = 0;
   int n_req = 0, last_row_edge = 0, done_cyc = 0;

   logic [N-1:0] m_res;
   logic         m_ok;
   int           m_it;

   function automatic logic [N-1:0] rnd256();
      logic [N-1:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   // Info columns weight 3; parity column i covers rows i and i+1.
   task automatic build_h();
      for (int r = 0; r < M; r++) Hrows[r] = '0;
      for (int c = 0; c < 128; c++) begin
         Hrows[c][c]             = 1'b1;
         Hrows[(c + 43) % M][c]  = 1'b1;
         Hrows[(c + 85) % M][c]  = 1'b1;
      end
      for (int i = 0; i < M; i++) begin
         Hrows[i][128 + i] = 1'b1;
         if (i + 1 < M) Hrows[i + 1][128 + i] = 1'b1;
      end
   endtask

   function automatic logic [N-1:0] encode(input logic [127:0] u);
      logic [N-1:0] c;
      logic         p;
      c = '0;
      c[127:0] = u;
      p = 1'b0;
      for (int i = 0; i < M; i++) begin
         p = p ^ (^(Hrows[i][127:0] & u));
         c[128 + i] = p;
      end
      return c;
   endfunction

   function automatic logic [N-1:0] add_errs(input logic [N-1:0] c,
                                             input int n);
      logic [N-1:0] msk;
      msk = '0;
      for (int k = 0; k < 4000 && $countones(msk) < n; k++)
         msk[$urandom_range(N - 1, 0)] = 1'b1;
      return c ^ msk;
   endfunction

   // Reference: count failed checks per bit, flip the worst bits.
   task automatic model(input logic [N-1:0] c);
      logic [N-1:0] w;
      int cntv [N];
      int nun, mx;
      w = c;
      m_ok = 1'b0;
      m_it = 0;
      for (int t = 1; t <= IT; t++) begin
         nun = 0;
         for (int j = 0; j < N; j++) cntv[j] = 0;
         for (int r = 0; r < M; r++)
            if (^(Hrows[r] & w)) begin
               nun++;
               for (int j = 0; j < N; j++)
                  if (Hrows[r][j]) cntv[j]++;
            end
         m_it = t;
         if (nun == 0) begin
            m_ok = 1'b1;
            break;
         end
         if (t == IT) break;
         mx = 0;
         for (int j = 0; j < N; j++) begin
            if (cntv[j] > 7) cntv[j] = 7;
            if (cntv[j] > mx) mx = cntv[j];
         end
         for (int j = 0; j < N; j++)
            if (cntv[j] == mx) w[j] = ~w[j];
      end
      m_res = w;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs,
                      input logic [N-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_down"}, N'(bus.decode_down), '0);
      chk({tag, "_readh"}, N'(bus.decoder_read_H), '0);
      chk({tag, "_crr"}, N'(bus.code_ready_receive), '0);
      chk({tag, "_seq"}, bus.Decoded_sequence, '0);
      chk({tag, "_succ"}, N'(bus.decode_success), '0);
      chk({tag, "_iter"}, N'(bus.iter_cnt), '0);
   endtask

   task automatic do_start(input logic [N-1:0] c, input string tag);
      logic got;
      got = 1'b0;
      bus.code_in = c;
      bus.code_ready = 1'b1;
      n_req = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.code_ready_receive) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_accept"}, N'(got), N'(1));
      bus.code_ready = 1'b0;
   endtask

   task automatic do_wait(input logic [N-1:0] c, input string tag);
      logic got;
      got = 1'b0;
      model(c);
      for (int k = 0; k < 4000; k++) begin
         if (bus.decode_down) begin
            got = 1'b1;
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_done"}, N'(got), N'(1));
      chk({tag, "_seq"}, bus.Decoded_sequence, m_res);
      chk({tag, "_succ"}, N'(bus.decode_success), N'(m_ok));
      chk({tag, "_iter"}, N'(bus.iter_cnt), N'(m_it));
      chk({tag, "_reqs"}, N'(n_req), N'(m_it));
   endtask

   task automatic do_ack(input string tag);
      bus.decode_down_receive = 1'b1;
      @(negedge clk);
      bus.decode_down_receive = 1'b0;
      chk({tag, "_ack"}, N'(bus.decode_down), '0);
   endtask

   task automatic run(input logic [N-1:0] c, input string tag);
      do_start(c, tag);
      do_wait(c, tag);
      do_ack(tag);
   endtask

   // H_ROM model: answers each request, then streams rows 0..M-1.
   initial begin
      bus.H_read_receive = 1'b0;
      bus.H_valid = 1'b0;
      bus.dout_H = '0;
      forever begin
         @(negedge clk);
         bus.H_read_receive = 1'b0;
         bus.H_valid = 1'b0;
         if (!rst_n) begin
            ph = 0;
            continue;
         end
         case (ph)
            0, 1: begin
               if (ph == 0 && bus.decoder_read_H) begin
                  dly = rdly;
                  ph = 1;
               end
               if (ph == 1) begin
                  if (dly == 0) begin
                     bus.H_read_receive = 1'b1;
                     n_req++;
                     ph = 2; row = 0; ex = 0; tog = 0;
                  end else dly--;
               end
            end
            default: begin
               if (gap != 0 && tog != 0) begin
                  tog = 0;
                  bus.dout_H = rnd256();
               end else begin
                  tog = 1;
                  if (row < M) begin
                     bus.H_valid = 1'b1;
                     bus.dout_H = Hrows[row];
                     if (row == M - 1) last_row_edge = cyc + 1;
                     row++;
                  end else if (ex < nextra) begin
                     bus.H_valid = 1'b1;
                     bus.dout_H = rnd256();
                     ex++;
                  end else ph = 0;
               end
            end
         endcase
      end
   end

   initial begin
      logic [N-1:0] c3, r3, c, c2, sv_seq;
      logic         r3_ok, sv_ok;
      int           r3_it;
      logic [5:0]   sv_it;
      build_h();
      rst_n = 1'b0;
      bus.code_ready = 1'b0;
      bus.code_in = '0;
      bus.decode_down_receive = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run('0, "zero");
      chk("zero_latency", N'(done_cyc - last_row_edge), N'(1));
      chk("zero_iter_is1", N'(bus.iter_cnt), N'(1));

      c3 = add_errs('0, 0);
      c3 = encode({$urandom(), $urandom(), $urandom(), $urandom()});
      c3[5] = ~c3[5];
      run(c3, "bit5");
      r3 = bus.Decoded_sequence;
      r3_ok = bus.decode_success;
      r3_it = int'(bus.iter_cnt);

      c = add_errs(encode({$urandom(), $urandom(), $urandom(),
                           $urandom()}), 20);
      run(c, "err20");

      gap = 1; rdly = 7; nextra = 3;
      run(c3, "gap");
      chk("gap_same_seq", bus.Decoded_sequence, r3);
      chk("gap_same_succ", N'(bus.decode_success), N'(r3_ok));
      chk("gap_same_iter", N'(bus.iter_cnt), N'(r3_it));

      for (int i = 0; i < 6; i++) begin
         gap = $urandom_range(1, 0);
         rdly = $urandom_range(4, 0);
         nextra = $urandom_range(2, 0);
         c = add_errs(encode({$urandom(), $urandom(), $urandom(),
                              $urandom()}), $urandom_range(6, 0));
         run(c, $sformatf("rnd%0d", i));
      end
      gap = 0; rdly = 0; nextra = 0;

      c = add_errs(encode({$urandom(), $urandom(), $urandom(),
                           $urandom()}), 2);
      do_start(c, "hold");
      do_wait(c, "hold");
      sv_seq = bus.Decoded_sequence;
      sv_ok = bus.decode_success;
      sv_it = bus.iter_cnt;
      c2 = add_errs(encode({$urandom(), $urandom(), $urandom(),
                            $urandom()}), 1);
      bus.code_in = c2;
      bus.code_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_down", N'(bus.decode_down), N'(1));
         chk("hold_seq", bus.Decoded_sequence, sv_seq);
         chk("hold_succ", N'(bus.decode_success), N'(sv_ok));
         chk("hold_iter", N'(bus.iter_cnt), N'(sv_it));
         chk("hold_crr", N'(bus.code_ready_receive), '0);
      end
      n_req = 0;
      bus.decode_down_receive = 1'b1;
      @(negedge clk);
      bus.decode_down_receive = 1'b0;
      chk("hold_release", N'(bus.decode_down), '0);
      @(negedge clk);
      chk("hold_newacc", N'(bus.code_ready_receive), N'(1));
      bus.code_ready = 1'b0;
      do_wait(c2, "after_hold");
      do_ack("after_hold");

      c = add_errs(encode({$urandom(), $urandom(), $urandom(),
                           $urandom()}), 1);
      do_start(c, "midrst");
      for (int k = 0; k < 1000 && !(ph == 2 && row >= 60); k++)
         @(negedge clk);
      chk("midrst_row", N'(row), N'(60));
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      run(c, "postrst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ldpc_bf_decoder.md
Name: ldpc_bf_decoder

Overview:
Hard-decision bit-flipping LDPC decoder. It is the receive-side counterpart of the team's systematic encoder. It accepts a CodeLen-bit hard-decision codeword and streams the H matrix row-by-row from an H_ROM each iteration. Per iteration it computes the syndrome and per-bit unsatisfied-check counts, then flips the bits with the maximum count. It stops on a zero syndrome or after Iteration_Times iterations, and hands the result to the control block with a down/receive handshake.

Parameters:
CodeLen, 256, codeword length and H_ROM row width
ChkLen, 128, number of parity checks (H rows)
ChkLen_bits, 8, width of the row counter; must hold the value ChkLen
column_weight, 3, max ones per H column; bounds the unsatisfied counters
CNT_bits, 3, per-bit unsatisfied counter width; 2^CNT_bits-1 >= column_weight
Iteration_Times, 50, maximum syndrome evaluations per codeword
ITER_bits, 6, iteration counter width; 2^ITER_bits-1 >= Iteration_Times

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
code_ready  input  1  channel has a codeword waiting
code_in  input  CodeLen  received hard-decision codeword
code_ready_receive  output  1  decoder has latched code_in (1-cycle pulse)
decoder_read_H  output  1  request an H_ROM pass (rows 0..ChkLen-1)
H_read_receive  input  1  H_ROM has accepted the request
H_valid  input  1  dout_H holds a valid row this cycle
dout_H  input  CodeLen  current H row, rows delivered in order 0..ChkLen-1
decode_down  output  1  decode finished; outputs valid
decode_down_receive  input  1  control has taken the result
Decoded_sequence  output  CodeLen  corrected codeword
decode_success  output  1  1 = final syndrome all-zero
iter_cnt  output  ITER_bits  syndrome evaluations performed (1..Iteration_Times)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Internal codeword, counters, row index, syndrome-OR flag and iteration count cleared. Reset at any point, including mid-ACC or mid-END, aborts the decode. No partial result is kept.
- IDLE: on code_ready=1, latch code_in into the working codeword, pulse code_ready_receive for one cycle, clear iter_cnt, go to REQ. code_ready is ignored in all other states.
- REQ: decoder_read_H=1, held until H_read_receive=1. On that cycle drive decoder_read_H=0 next, clear the row index, all unsatisfied counters and the syndrome flag, and go to ACC.
- ACC: on each cycle with H_valid=1 and row index < ChkLen:
  - s = XOR-reduce(dout_H & codeword).
  - If s=1: set the syndrome flag, and for every bit j with dout_H[j]=1 increment cnt[j], saturating at 2^CNT_bits-1.
  - Increment the row index.
  - H_valid=0 cycles hold everything. When the row index reaches ChkLen, go to EVAL; further H_valid pulses are ignored.
- EVAL (one cycle): iter_cnt <= iter_cnt+1. Then:
  - syndrome flag=0: decode_success=1, go to END.
  - else if iter_cnt+1 == Iteration_Times: decode_success=0, go to END with the codeword unflipped.
  - else: compute max = max over j of cnt[j] (nonzero whenever the flag is set). Flip every bit j with cnt[j]==max, then go to REQ for the next iteration.
- END: Decoded_sequence = working codeword, decode_down=1. All three outputs are held stable while waiting. On decode_down_receive=1, decode_down goes to 0 on the next edge and the state returns to IDLE. Decoded_sequence, decode_success and iter_cnt keep their values until the next EVAL.
- Latency: each iteration takes 1 request cycle + handshake wait + ChkLen valid rows + 1 EVAL cycle. There is no combinational path from any input to any output.
- The output is the full codeword in H column order. Column de-permutation and info extraction belong downstream.

Test Plan:
- All-zero code_in, H_ROM streams 128 rows with H_valid always 1 -> decode_success=1, iter_cnt=1, Decoded_sequence=0; decode_down rises 1 cycle after the 128th row is consumed.
- Valid encoder codeword with bit 5 flipped -> decode_success=1, iter_cnt=2, Decoded_sequence equals the original codeword.
- Noise pattern with 20 random errors, Iteration_Times=3 -> decode_success=0, iter_cnt=3, exactly 3 decoder_read_H requests issued, decode_down=1.
- H_valid deasserted every other cycle and H_read_receive delayed 7 cycles -> identical result to the gap-free run; only rows with H_valid=1 are counted, and extra H_valid pulses after row 127 are ignored.
- decode_down_receive held low 10 cycles while code_ready=1 -> outputs stable, no code_ready_receive pulse. Then decode_down_receive=1 -> decode_down=0 next edge, new codeword accepted from IDLE.
- rst pulled low mid-ACC (row 60) -> all outputs 0 immediately. After release, the next codeword decodes correctly from row 0.
